// File: rtl/player_uart_tx.sv
// UART transmitter for the player status byte: 8N1 LSB-first frames on every byte change,
// plus a periodic keepalive resend. Define UART_TX_PARITY_EN for 8E1 framing.
module player_uart_tx #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int BAUD          = 115_200,
    parameter int CLKS_PER_BIT  = CLK_HZ / BAUD,
    parameter int RESEND_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int RW = (RESEND_CYCLES > 1) ? $clog2(RESEND_CYCLES) : 1;
    localparam logic [BW-1:0] BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
    localparam logic [RW-1:0] RESEND_LAST = (RESEND_CYCLES > 0) ? RW'(RESEND_CYCLES - 1) : '0;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          state, state_n;
    logic [BW-1:0]   baud_cnt, baud_n;
    logic [2:0]      bit_cnt, bit_n;
    logic [7:0]      shift_reg, shift_n;
    logic [7:0]      last_sent, last_n;
    logic            force_send, force_n;
    logic [RW-1:0]   resend_cnt, resend_n;
    logic            tx_n;
    logic            baud_end;
    logic            resend_hit;
    logic            trigger;

    assign baud_end   = (baud_cnt == BAUD_LAST);
    assign resend_hit = (RESEND_CYCLES != 0) && (resend_cnt == RESEND_LAST);
    assign trigger    = (data_in != last_sent) || force_send || resend_hit;

    // Decoded from registered state so both fall the instant rst asserts.
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_STOP) && baud_end;

    // NOTE: every next-value signal takes its hold value first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_n  = state;
        baud_n   = baud_cnt;
        bit_n    = bit_cnt;
        shift_n  = shift_reg;
        last_n   = last_sent;
        force_n  = force_send;
        resend_n = resend_cnt;
        tx_n     = tx;

        if (state != S_IDLE) begin
            baud_n = baud_end ? '0 : baud_cnt + 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (trigger) begin
                    shift_n  = data_in;
                    last_n   = data_in;
                    force_n  = 1'b0;
                    resend_n = '0;
                    baud_n   = '0;
                    tx_n     = 1'b0;
                    state_n  = S_START;
                end else if (RESEND_CYCLES != 0) begin
                    resend_n = resend_cnt + 1'b1;
                end
            end
            S_START: begin
                if (baud_end) begin
                    bit_n   = '0;
                    tx_n    = shift_reg[0];
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        // last_sent holds the byte in flight; shift_reg is consumed by now.
                        tx_n    = ^last_sent;
                        state_n = S_PARITY;
`else
                        tx_n    = 1'b1;
                        state_n = S_STOP;
`endif
                    end else begin
                        shift_n = {1'b0, shift_reg[7:1]};
                        bit_n   = bit_cnt + 1'b1;
                        tx_n    = shift_reg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    tx_n    = 1'b1;
                    state_n = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                tx_n    = 1'b1;
                state_n = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            last_sent  <= 8'h00;
            force_send <= 1'b1;
            resend_cnt <= '0;
            tx         <= 1'b1;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_n;
            bit_cnt    <= bit_n;
            shift_reg  <= shift_n;
            last_sent  <= last_n;
            force_send <= force_n;
            resend_cnt <= resend_n;
            tx         <= tx_n;
        end
    end

endmodule
